// File: rtl/irq_controller_if.sv
// Bus between irq_controller and its core/peripheral side: requests, enables, MRET in;
// trap request, cause and per-line acknowledge out. master = core side, slave = controller.
interface irq_controller_if #(
  parameter int unsigned N = 16
) ();
  logic [N-1:0] irq_req;
  logic [31:0]  mie;
  logic         mret;
  logic         irq;
  logic [31:0]  mcause;
  logic [N-1:0] irq_ret;

  modport master (
    output irq_req,
    output mie,
    output mret,
    input  irq,
    input  mcause,
    input  irq_ret
  );

  modport slave (
    input  irq_req,
    input  mie,
    input  mret,
    output irq,
    output mcause,
    output irq_ret
  );
endinterface

// File: rtl/irq_controller.sv
// Machine-level interrupt controller: fixed-priority, non-nesting, one trap per MRET.
// Define IRQ_EDGE_DETECT_EN for rising-edge capture; default build captures on level.
module irq_controller #(
  parameter int unsigned N = 16
) (
  input  logic              clock,
  input  logic              reset,
  irq_controller_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StTrap, StService} state_e;

  state_e       r_state;
  state_e       w_state_next;
  logic [N-1:0] r_pend;
  logic [N-1:0] w_pend_next;
  logic [N-1:0] w_set;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_en;
  logic [N-1:0] w_cur_onehot;
  logic [N-1:0] r_irq_ret;
  logic [31:0]  r_mcause;
  logic [3:0]   r_cur;
  logic [3:0]   w_sel;
  logic         w_any;
  logic         w_load;
  logic         w_ret_fire;
  logic         w_unused_mie;

  // Only mie[16+N-1:16] matters; the rest is intentionally ignored.
  assign w_unused_mie = ^bus.mie;

`ifdef IRQ_EDGE_DETECT_EN
  logic [N-1:0] r_hist;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
    end else begin
      r_hist <= bus.irq_req;
    end
  end

  assign w_set = bus.irq_req & ~r_hist;
`else
  assign w_set = bus.irq_req;
`endif

  assign w_en = r_pend & bus.mie[16 +: N];

  // Scan downward so the lowest enabled index wins.
  always_comb begin
    w_sel = '0;
    w_any = |w_en;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (w_en[i]) begin
        w_sel = 4'(i);
      end
    end
  end

  always_comb begin
    w_cur_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_cur_onehot[i] = (r_cur == 4'(i));
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_ret_fire   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_state_next = StTrap;
          w_load       = 1'b1;
        end
      end
      StTrap: begin
        w_state_next = StService;
      end
      StService: begin
        if (bus.mret) begin
          w_state_next = StIdle;
          w_ret_fire   = 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Clear the serviced line at the MRET edge so the following IDLE cycle cannot retake it;
  // a simultaneous new capture on that line overrides the clear.
  assign w_clr       = w_ret_fire ? w_cur_onehot : '0;
  assign w_pend_next = (r_pend & ~w_clr) | w_set;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_pend    <= '0;
      r_cur     <= '0;
      r_mcause  <= '0;
      r_irq_ret <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pend    <= w_pend_next;
      r_irq_ret <= w_ret_fire ? w_cur_onehot : '0;
      if (w_load) begin
        r_cur    <= w_sel;
        r_mcause <= 32'h8000_0000 | (32'd16 + 32'(w_sel));
      end
    end
  end

  assign bus.irq     = (r_state == StTrap);
  assign bus.mcause  = r_mcause;
  assign bus.irq_ret = r_irq_ret;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller; expectations adapt to IRQ_EDGE_DETECT_EN.
module tb_irq_controller;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  irq_controller_if #(.N(16)) bus ();

  irq_controller #(.N(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_irq(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      step();
      if (bus.irq === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.irq_req = '0;
    bus.mie     = '0;
    bus.mret    = 1'b0;
    #2;
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b expected 0", bus.irq);
    end
    n_checks++;
    if (bus.irq_ret !== 16'h0000) begin
      n_fail++; $display("FAIL reset_irq_ret: got %h expected 0000", bus.irq_ret);
    end
    n_checks++;
    if (bus.mcause !== 32'h0) begin
      n_fail++; $display("FAIL reset_mcause: got %h expected 00000000", bus.mcause);
    end
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    bit found;
    bus.mie        = 32'h0001_0000;
    bus.irq_req[0] = 1'b1;
    step();
    bus.irq_req[0] = 1'b0;
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: irq got %b expected 0 right after capture", bus.irq);
    end
    step();
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_fail++; $display("FAIL single_irq: got %b expected 1", bus.irq);
    end
    n_checks++;
    if (bus.mcause !== 32'h8000_0010) begin
      n_fail++; $display("FAIL single_mcause: got %h expected 80000010", bus.mcause);
    end
    step();
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL single_irq_width: got %b expected 0", bus.irq);
    end
    bus.mret = 1'b1;
    step();
    bus.mret = 1'b0;
    n_checks++;
    if (bus.irq_ret !== 16'h0001) begin
      n_fail++; $display("FAIL single_irq_ret: got %h expected 0001", bus.irq_ret);
    end
    step();
    n_checks++;
    if (bus.irq_ret !== 16'h0000) begin
      n_fail++; $display("FAIL single_irq_ret_width: got %h expected 0000", bus.irq_ret);
    end
    n_checks++;
    if (bus.mcause !== 32'h8000_0010) begin
      n_fail++; $display("FAIL single_mcause_hold: got %h expected 80000010", bus.mcause);
    end
    wait_irq(5, found);
    n_checks++;
    if (found !== 1'b0) begin
      n_fail++; $display("FAIL single_no_retrap: got irq=%b expected none", found);
    end
  endtask

  task automatic test_priority();
    bit found;
    int c1;
    bus.mie     = 32'h0028_0000;
    bus.irq_req = 16'h0028;
    step();
    bus.irq_req = '0;
    wait_irq(6, found);
    c1 = $realtime > 0 ? int'($time / 10) : 0;
    n_checks++;
    if (found !== 1'b1 || bus.mcause !== 32'h8000_0013) begin
      n_fail++; $display("FAIL prio_first: found=%b mcause=%h expected 1/80000013", found, bus.mcause);
    end
    step();
    bus.mret = 1'b1;
    step();
    bus.mret = 1'b0;
    n_checks++;
    if (bus.irq_ret !== 16'h0008) begin
      n_fail++; $display("FAIL prio_ret3: got %h expected 0008", bus.irq_ret);
    end
    wait_irq(6, found);
    n_checks++;
    if (found !== 1'b1 || bus.mcause !== 32'h8000_0015) begin
      n_fail++; $display("FAIL prio_second: found=%b mcause=%h expected 1/80000015", found, bus.mcause);
    end
    n_checks++;
    if (int'($time / 10) - c1 < 3) begin
      n_fail++; $display("FAIL prio_spacing: got %0d cycles expected >= 3", int'($time / 10) - c1);
    end
    step();
    bus.mret = 1'b1;
    step();
    bus.mret = 1'b0;
    n_checks++;
    if (bus.irq_ret !== 16'h0020) begin
      n_fail++; $display("FAIL prio_ret5: got %h expected 0020", bus.irq_ret);
    end
    step();
  endtask

  task automatic test_masked();
    bit found;
    bus.mie        = 32'h0;
    bus.irq_req[2] = 1'b1;
    step();
    bus.irq_req[2] = 1'b0;
    wait_irq(5, found);
    n_checks++;
    if (found !== 1'b0) begin
      n_fail++; $display("FAIL masked_no_irq: got irq=%b expected none", found);
    end
    n_checks++;
    if (dut.r_pend[2] !== 1'b1) begin
      n_fail++; $display("FAIL masked_pend_held: got %b expected 1", dut.r_pend[2]);
    end
    bus.mie = 32'h0004_0000;
    wait_irq(4, found);
    n_checks++;
    if (found !== 1'b1 || bus.mcause !== 32'h8000_0012) begin
      n_fail++; $display("FAIL masked_take: found=%b mcause=%h expected 1/80000012", found, bus.mcause);
    end
    step();
    bus.mie  = 32'h0;
    bus.mret = 1'b1;
    step();
    bus.mret = 1'b0;
    n_checks++;
    if (bus.irq_ret !== 16'h0004) begin
      n_fail++; $display("FAIL masked_ret: got %h expected 0004", bus.irq_ret);
    end
    step();
  endtask

  task automatic test_set_wins();
    bit found;
    bus.mie        = 32'h0003_0000;
    bus.irq_req[1] = 1'b1;
    step();
    bus.irq_req[1] = 1'b0;
    wait_irq(4, found);
    n_checks++;
    if (found !== 1'b1 || bus.mcause !== 32'h8000_0011) begin
      n_fail++; $display("FAIL setwins_first: found=%b mcause=%h expected 1/80000011", found, bus.mcause);
    end
    step();
    bus.irq_req[0] = 1'b1;
    step();
    bus.irq_req[0] = 1'b0;
    bus.irq_req[1] = 1'b1;
    bus.mret       = 1'b1;
    step();
    bus.irq_req[1] = 1'b0;
    bus.mret       = 1'b0;
    n_checks++;
    if (bus.irq_ret !== 16'h0002) begin
      n_fail++; $display("FAIL setwins_ret1: got %h expected 0002", bus.irq_ret);
    end
    n_checks++;
    if (dut.r_pend[1:0] !== 2'b11) begin
      n_fail++; $display("FAIL setwins_pend: got %b expected 11", dut.r_pend[1:0]);
    end
    wait_irq(4, found);
    n_checks++;
    if (found !== 1'b1 || bus.mcause !== 32'h8000_0010) begin
      n_fail++; $display("FAIL setwins_line0: found=%b mcause=%h expected 1/80000010", found, bus.mcause);
    end
    step();
    bus.mret = 1'b1;
    step();
    bus.mret = 1'b0;
    wait_irq(4, found);
    n_checks++;
    if (found !== 1'b1 || bus.mcause !== 32'h8000_0011) begin
      n_fail++; $display("FAIL setwins_line1: found=%b mcause=%h expected 1/80000011", found, bus.mcause);
    end
    step();
    bus.mret = 1'b1;
    step();
    bus.mret = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bit found;
    bit ret_seen;
    bus.mie        = 32'h0001_0000;
    bus.irq_req[0] = 1'b1;
    step();
    bus.irq_req[0] = 1'b0;
    wait_irq(4, found);
    step();
    bus.irq_req[0] = 1'b1;
    step();
    bus.irq_req[0] = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.irq !== 1'b0 || bus.irq_ret !== 16'h0 || bus.mcause !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: irq=%b ret=%h mcause=%h expected 0/0000/00000000",
                         bus.irq, bus.irq_ret, bus.mcause);
    end
    n_checks++;
    if (dut.r_pend !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_pend: got %h expected 0000", dut.r_pend);
    end
    n_checks++;
    if (2'(dut.r_state) !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_state: got %0d expected 0 (idle)", 2'(dut.r_state));
    end
    step();
    reset    = 1'b0;
    ret_seen = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.irq_ret !== 16'h0) ret_seen = 1'b1;
      if (bus.irq === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (ret_seen !== 1'b0 || found !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_quiet: irq_ret_seen=%b irq_seen=%b expected 0/0", ret_seen, found);
    end
  endtask

  task automatic test_level_hold();
    bit found;
    bit exp_found;
    bus.mie        = 32'h0010_0000;
    bus.irq_req[4] = 1'b1;
    for (int i = 0; i < 3; i++) begin
`ifdef IRQ_EDGE_DETECT_EN
      exp_found = (i == 0);
`else
      exp_found = 1'b1;
`endif
      wait_irq(8, found);
      n_checks++;
      if (found !== exp_found) begin
        n_fail++; $display("FAIL hold_trap%0d: got %b expected %b", i, found, exp_found);
      end
      if (found) begin
        n_checks++;
        if (bus.mcause !== 32'h8000_0014) begin
          n_fail++; $display("FAIL hold_mcause%0d: got %h expected 80000014", i, bus.mcause);
        end
        step();
        if (i == 2) bus.irq_req[4] = 1'b0;
        step();
        bus.mret = 1'b1;
        step();
        bus.mret = 1'b0;
        n_checks++;
        if (bus.irq_ret !== 16'h0010) begin
          n_fail++; $display("FAIL hold_ret%0d: got %h expected 0010", i, bus.irq_ret);
        end
      end
    end
    bus.irq_req[4] = 1'b0;
    wait_irq(6, found);
    n_checks++;
    if (found !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: got irq=%b expected none", found);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_priority();
    test_masked();
    test_set_wins();
    test_reset_mid();
    test_level_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
